// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl
//
// Burst sequencer in front of an interleaved memory with a combinational
// read port. It accepts one read or write burst request at a time and streams
// its words at consecutive addresses, one per cycle. Because the addresses are
// consecutive, accesses alternate between the even and odd memory modules.
// Read data passes through a single output register that honours backpressure.
//
// Parameters
//   M  memory word width
//   K  memory address width
//   L  burst length field width (a burst carries req_len+1 words, 1..2^L)
//
// Ports
//   clock, reset_n          system clock, asynchronous active-low reset
//   req_valid/req_ready     burst request handshake (ready only when idle)
//   req_write               1 = write burst, 0 = read burst
//   req_addr, req_len       start word address, word count minus one
//   wr_data/wr_valid/wr_ready   write stream in (consumed when valid & ready)
//   rd_data/rd_valid/rd_ready   registered read stream out
//   done                    one-cycle pulse at burst completion
//   A, WD, WE               memory address, write data, write enable
//   RA                      memory read data, combinational from A
module mem_burst_ctrl #(
    parameter int M = 8,
    parameter int K = 11,
    parameter int L = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [K-1:0] req_addr,
    input  logic [L-1:0] req_len,
    input  logic [M-1:0] wr_data,
    input  logic         wr_valid,
    output logic         wr_ready,
    output logic [M-1:0] rd_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic         done,
    output logic [K-1:0] A,
    output logic [M-1:0] WD,
    output logic         WE,
    input  logic [M-1:0] RA
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } state_t;

    // cnt is one bit wider than req_len so a full 2^L-word burst fits.
    localparam logic [L:0] CNT_ONE = (L+1)'(1);

    state_t       state, state_nxt;
    logic [K-1:0] addr, addr_nxt;
    logic [L:0]   cnt, cnt_nxt;
    logic [M-1:0] rd_data_nxt;
    logic         rd_valid_nxt;
    logic         load;

    // The output register may be refilled whenever it is empty or is being
    // drained in this same cycle, which keeps reads at one word per cycle.
    assign load = (cnt != '0) && (!rd_valid || rd_ready);

    assign A  = addr;
    assign WD = wr_data;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_nxt    = state;
        addr_nxt     = addr;
        cnt_nxt      = cnt;
        rd_data_nxt  = rd_data;
        rd_valid_nxt = rd_valid;
        req_ready    = 1'b0;
        wr_ready     = 1'b0;
        WE           = 1'b0;
        done         = 1'b0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_nxt  = req_addr;
                    cnt_nxt   = {1'b0, req_len} + CNT_ONE;
                    state_nxt = req_write ? WRITE : READ;
                end
            end

            WRITE: begin
                wr_ready = 1'b1;
                WE       = wr_valid;
                if (wr_valid) begin
                    addr_nxt = addr + 1'b1;
                    cnt_nxt  = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state_nxt = DONE;
                    end
                end
            end

            READ: begin
                if (load) begin
                    rd_data_nxt  = RA;
                    rd_valid_nxt = 1'b1;
                    addr_nxt     = addr + 1'b1;
                    cnt_nxt      = cnt - CNT_ONE;
                end else if (rd_valid && rd_ready) begin
                    rd_valid_nxt = 1'b0;
                end
                // The last word has been handed over once nothing is left to
                // fetch and the consumer takes the held word.
                if ((cnt == '0) && rd_valid && rd_ready) begin
                    state_nxt = DONE;
                end
            end

            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            addr     <= '0;
            cnt      <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values computed from the same pre-edge state.
            state    <= state_nxt;
            addr     <= addr_nxt;
            cnt      <= cnt_nxt;
            rd_data  <= rd_data_nxt;
            rd_valid <= rd_valid_nxt;
        end
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl. A simple memory with a combinational
// read port sits behind the DUT. Expected values come from a word-level
// reference memory and from burst arithmetic: the start address plus the
// words transferred so far, and the number of words consumed.
module tb_mem_burst_ctrl;

    localparam int M     = 8;
    localparam int K     = 11;
    localparam int L     = 4;
    localparam int DEPTH = 2 ** K;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_write = 1'b0;
    logic [K-1:0] req_addr = '0;
    logic [L-1:0] req_len = '0;
    logic [M-1:0] wr_data = '0;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic [M-1:0] rd_data;
    logic         rd_valid;
    logic         rd_ready = 1'b0;
    logic         done;
    logic [K-1:0] A;
    logic [M-1:0] WD;
    logic         WE;
    logic [M-1:0] RA;

    int n_checks = 0;
    int n_pass   = 0;

    logic [M-1:0] mem     [0:DEPTH-1];
    logic [M-1:0] ref_mem [0:DEPTH-1];
    logic [M-1:0] wdata   [0:15];

    mem_burst_ctrl #(.M(M), .K(K), .L(L)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .done      (done),
        .A         (A),
        .WD        (WD),
        .WE        (WE),
        .RA        (RA)
    );

    always #5 clock = ~clock;

    // Memory behind the sequencer: combinational read, write on the edge.
    assign RA = mem[A];
    always @(posedge clock) begin
        if (WE) mem[A] <= WD;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Request lines toggle randomly while a burst runs; they must be ignored.
    task automatic drive_noise();
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_addr  = K'($urandom);
        req_len   = L'($urandom);
    endtask

    task automatic request(input int start, input int len, input logic wr);
        @(negedge clock);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = K'(start);
        req_len   = L'(len);
        #1;
        check("req_ready idle", req_ready, 1);
    endtask

    task automatic finish_burst(input string tag);
        @(negedge clock);
        drive_noise();
        wr_valid = 1'($urandom_range(0, 1));
        rd_ready = 1'($urandom_range(0, 1));
        #1;
        check({tag, " done pulse"}, done, 1);
        check({tag, " done WE"}, WE, 0);
        check({tag, " done req_ready"}, req_ready, 0);
        check({tag, " done rd_valid"}, rd_valid, 0);
        @(negedge clock);
        req_valid = 1'b0;
        wr_valid  = 1'b0;
        #1;
        check({tag, " idle done"}, done, 0);
        check({tag, " idle req_ready"}, req_ready, 1);
    endtask

    // Write wdata[0..len]. Cycle j uses pat[j] for wr_valid (1 beyond pat_len),
    // or a random wr_valid when rnd is set.
    task automatic write_burst(input int start, input int len, input bit rnd,
                               input logic [31:0] pat, input int pat_len);
        int   n = len + 1;
        int   nw = 0;
        int   cyc = 0;
        logic v;
        request(start, len, 1'b1);
        while (nw < n && cyc < 8 * n + 16) begin
            @(negedge clock);
            drive_noise();
            if (rnd) v = (cyc >= 4 * n) ? 1'b1 : 1'($urandom_range(0, 1));
            else     v = (cyc < pat_len) ? pat[cyc] : 1'b1;
            wr_valid = v;
            wr_data  = wdata[nw];
            rd_ready = 1'($urandom_range(0, 1));
            #1;
            check("wr WE", WE, v);
            check("wr A", A, (start + nw) % DEPTH);
            check("wr WD", WD, wdata[nw]);
            check("wr wr_ready", wr_ready, 1);
            check("wr req_ready", req_ready, 0);
            check("wr done", done, 0);
            if (v) begin
                ref_mem[(start + nw) % DEPTH] = wdata[nw];
                nw++;
            end
            cyc++;
        end
        check("wr word count", nw, n);
        finish_burst("wr");
    endtask

    // Read len+1 words. Loop cycle j (from the first rd_valid cycle on) uses
    // pat[j] for rd_ready (1 beyond pat_len), or a random rd_ready when rnd.
    task automatic read_burst(input int start, input int len, input bit rnd,
                              input logic [31:0] pat, input int pat_len);
        int   n = len + 1;
        int   k = 0;
        int   cyc = 0;
        int   fetched;
        logic r;
        request(start, len, 1'b0);
        @(negedge clock);
        drive_noise();
        rd_ready = 1'($urandom_range(0, 1));
        wr_valid = 1'($urandom_range(0, 1));
        #1;
        check("rd first rd_valid", rd_valid, 0);
        check("rd first A", A, start % DEPTH);
        check("rd first WE", WE, 0);
        check("rd first wr_ready", wr_ready, 0);
        while (k < n && cyc < 8 * n + 16) begin
            @(negedge clock);
            drive_noise();
            if (rnd) r = (cyc >= 4 * n) ? 1'b1 : 1'($urandom_range(0, 1));
            else     r = (cyc < pat_len) ? pat[cyc] : 1'b1;
            rd_ready = r;
            wr_valid = 1'($urandom_range(0, 1));
            #1;
            fetched = (k + 1 < n) ? k + 1 : n;
            check("rd rd_valid", rd_valid, 1);
            check("rd rd_data", rd_data, ref_mem[(start + k) % DEPTH]);
            check("rd A", A, (start + fetched) % DEPTH);
            check("rd WE", WE, 0);
            check("rd done", done, 0);
            check("rd req_ready", req_ready, 0);
            if (r) k++;
            cyc++;
        end
        check("rd word count", k, n);
        finish_burst("rd");
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) wdata[i] = M'($urandom);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int len;

        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end

        // Reset state.
        wr_data = 8'h5A;
        #12;
        check("rst req_ready", req_ready, 1);
        check("rst wr_ready", wr_ready, 0);
        check("rst rd_valid", rd_valid, 0);
        check("rst rd_data", rd_data, 0);
        check("rst done", done, 0);
        check("rst WE", WE, 0);
        check("rst A", A, 0);
        check("rst WD", WD, 8'h5A);
        @(negedge clock);
        reset_n = 1'b1;

        // Reset mid-write: two of four words land, then the burst is dropped.
        wdata[0] = 8'h3C;
        wdata[1] = 8'hC3;
        request(5, 3, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            req_valid = 1'b0;
            wr_valid  = 1'b1;
            wr_data   = wdata[i];
            #1;
            check("rstw WE", WE, 1);
            check("rstw A", A, 5 + i);
            ref_mem[5 + i] = wdata[i];
        end
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstw WE drop", WE, 0);
        check("rstw req_ready", req_ready, 1);
        check("rstw wr_ready", wr_ready, 0);
        check("rstw done", done, 0);
        check("rstw A", A, 0);
        @(negedge clock);
        wr_valid = 1'b0;
        reset_n  = 1'b1;
        #1;
        check("rstw no done", done, 0);
        @(negedge clock);
        #1;
        check("rstw still no done", done, 0);
        read_burst(5, 1, 1'b0, 32'hFFFF_FFFF, 0);

        // Write then read, continuous.
        for (int i = 0; i < 4; i++) wdata[i] = M'(8'hA0 + i);
        write_burst(10, 3, 1'b0, 32'hFFFF_FFFF, 0);
        read_burst(10, 3, 1'b0, 32'hFFFF_FFFF, 0);

        // Address wrap at the top of the address space.
        for (int i = 0; i < 4; i++) wdata[i] = M'(i + 1);
        write_burst(DEPTH - 2, 3, 1'b0, 32'hFFFF_FFFF, 0);
        read_burst(DEPTH - 2, 1, 1'b0, 32'hFFFF_FFFF, 0);
        read_burst(0, 1, 1'b0, 32'hFFFF_FFFF, 0);
        read_burst(DEPTH - 2, 3, 1'b1, 32'h0, 0);

        // Write stall: wr_valid 1,0,0,1,1,0,1.
        fill_random(4);
        write_burst(100, 3, 1'b0, 32'b1011001, 7);

        // Read backpressure: rd_ready low for three cycles after first rd_valid.
        read_burst(100, 2, 1'b0, 32'b000, 3);

        // Maximum length burst.
        fill_random(16);
        write_burst(300, 15, 1'b0, 32'hFFFF_FFFF, 0);
        read_burst(300, 15, 1'b0, 32'hFFFF_FFFF, 0);

        // Randomised bursts with random stalls and backpressure.
        for (int b = 0; b < 8; b++) begin
            start = int'($urandom_range(0, DEPTH - 1));
            len   = int'($urandom_range(0, 15));
            fill_random(len + 1);
            write_burst(start, len, 1'b1, 32'h0, 0);
            read_burst(start, int'($urandom_range(0, 15)), 1'b1, 32'h0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
